l1_cache_sa_vc: RTL and testbench
=================================

// Module: l1_cache_sa_vc
// PURPOSE
// Parametrised N-way set-associative L1 data cache with victim-cache (VC) backing and per-byte write enables.
// Sits between the CPU and the victim cache / memory. Successor to the direct-mapped L1: adds WAYS,
//   ready/valid handshakes on the CPU and memory request channels, round-robin replacement and saturating stat counters.
// Write-back/write-allocate. Dirty lines leave only through the VC evict channel; the memory channel is read-only.
// PARAMETERS
// ADDR_WIDTH 32 - byte address width
// DATA_WIDTH 32 - CPU word width (multiple of 8)
// CACHE_BYTES 512 - total data capacity in bytes
// LINE_BYTES 16 - line size in bytes
// WAYS 2 - associativity (power of 2, >=1); SETS = CACHE_BYTES/(LINE_BYTES*WAYS)
// VICTIM_TAG_WIDTH 28 - must equal ADDR_WIDTH-log2(LINE_BYTES); an elaboration-time $error fires otherwise
// STAT_WIDTH 32 - width of each stat counter
// PORTS
// clk              in  1             clock, all logic on rising edge
// rst_n            in  1             asynchronous active-low reset
// cpu_req_valid    in  1             CPU request valid
// cpu_req_ready    out 1             high only in IDLE; request accepted when valid&&ready
// cpu_req_rw       in  1             0=read, 1=write
// cpu_req_addr     in  ADDR_WIDTH    byte address (word-aligned)
// cpu_req_wdata    in  DATA_WIDTH    write data
// cpu_req_be       in  DATA_WIDTH/8  byte enables for writes
// cpu_resp_valid   out 1             one-cycle response pulse
// cpu_resp_rdata   out DATA_WIDTH    addressed word after any write merge
// mem_req_valid    out 1             line-fill request; held until mem_req_ready
// mem_req_ready    in  1             memory accepts the request
// mem_req_addr     out ADDR_WIDTH    line-aligned fill address
// mem_resp_valid   in  1             fill data valid (single beat)
// mem_resp_rdata   in  LINE_BYTES*8  fill line
// vc_probe_valid   out 1             VC probe; held until vc_probe_ready
// vc_probe_tag     out VICTIM_TAG_WIDTH  {tag,index} of the missing line
// vc_probe_ready   in  1             VC probe result valid this cycle
// vc_probe_hit / vc_probe_dirty  in  1  VC hit flag / dirty flag of the returned line
// vc_probe_line    in  LINE_BYTES*8  VC line returned on hit
// vc_evict_valid   out 1             evict request; held until vc_evict_ack
// vc_evict_tag     out VICTIM_TAG_WIDTH  {victim tag,index}
// vc_evict_line / vc_evict_dirty  out  LINE_BYTES*8 / 1  evicted line data / dirty flag
// vc_evict_ack     in  1             VC accepted the evict
// stat_hits / stat_misses / stat_vc_hits  out  STAT_WIDTH  saturating counters
// BEHAVIOUR
// Reset: every output 0 except cpu_req_ready=1. All valid/dirty bits, RR pointers and counters cleared.
//   A reset in any state aborts the transaction; in-flight handshakes are dropped and no response is given.
// Request latched at acceptance; input changes afterwards have no effect.
// FSM states: IDLE, LOOKUP, VC_PROBE, EVICT, MEM_REQ, MEM_WAIT, INSTALL, RESPOND.
//   IDLE->LOOKUP on accept.
//   LOOKUP: hit -> RESPOND; miss -> VC_PROBE.
//   VC_PROBE->EVICT if the victim way is valid, else -> INSTALL on VC hit, else -> MEM_REQ.
//   EVICT-> INSTALL on VC hit, else -> MEM_REQ, on ack.
//   MEM_REQ->MEM_WAIT on mem_req_ready. MEM_WAIT->INSTALL on mem_resp_valid.
//   INSTALL->RESPOND. RESPOND->IDLE.
// Hit latency: accept in cycle N, cpu_resp_valid high in cycle N+2. A write hit merges bytes by cpu_req_be and sets dirty.
// Victim way: lowest-index invalid way; if none, the set's RR pointer. The pointer advances (mod WAYS) only on an install into a full set.
// Probe/evict/mem payloads stay stable while valid is high. VC outputs are sampled in the cycle vc_probe_ready=1.
// Evict is issued only after the probe completes, so a line swapped out of VC never coexists with its replacement.
// INSTALL writes line, tag and valid=1. A write merges wdata by be, then dirty = write | (VC hit & vc_probe_dirty).
// Stray mem_resp_valid, vc_probe_ready or vc_evict_ack outside their wait states are ignored.
// Counters: hit +1 in LOOKUP on hit; miss +1 in LOOKUP on miss; vc_hit +1 on sampled VC hit; all saturate at all-ones.
// TESTING
// 1. Cold read 0x100 -> probe tag 0x0000010, VC miss -> no evict; mem_req_addr=0x100; line word0=0xDEADBEEF -> rdata 0xDEADBEEF; stat_misses=1.
// 2. Read 0x100 again -> cpu_resp_valid at accept+2, no mem/VC traffic, rdata 0xDEADBEEF, stat_hits=1.
// 3. Write 0x104 wdata 0x000000AA be=4'b0001 (word was 0x11223344) -> read 0x104 returns 0x112233AA; line dirty.
// 4. Fill set 0 with 0x000 and 0x100, then read 0x200 -> evict way0: tag 0x0000000, dirty per history; RR pointer -> 1.
// 5. Read 0x000, VC returns hit dirty=1 -> no mem_req; evict of 0x100 line first; installed dirty; stat_vc_hits=1.
// 6. rst_n low during MEM_WAIT -> all outputs reset next cycle; a later read of 0x100 misses (stat_misses=1 after reset).

Source files
------------

// File: rtl/l1_cache_sa_vc.sv
// l1_cache_sa_vc: N-way set-associative write-back / write-allocate L1 data
// cache with a victim cache (VC) behind it and per-byte write enables.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cpu_req_*                  CPU request channel (valid/ready); latched on acceptance
//   cpu_resp_valid/rdata       one-cycle response with the addressed word after any merge
//   mem_req_*/mem_resp_*       read-only line-fill channel (request handshake, single-beat data)
//   vc_probe_*                 VC lookup for the missing line; result sampled when ready=1
//   vc_evict_*                 dirty or clean victim lines leave through here; held until ack
//   stat_hits/misses/vc_hits   saturating event counters
//
// A miss always probes the VC first; the victim (if the set is full) is evicted
// only after the probe completes, then the line comes from the VC or from memory.
module l1_cache_sa_vc #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int CACHE_BYTES      = 512,
    parameter int LINE_BYTES       = 16,
    parameter int WAYS             = 2,
    parameter int VICTIM_TAG_WIDTH = 28,
    parameter int STAT_WIDTH       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cpu_req_valid,
    output logic                        cpu_req_ready,
    input  logic                        cpu_req_rw,
    input  logic [ADDR_WIDTH-1:0]       cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]       cpu_req_wdata,
    input  logic [DATA_WIDTH/8-1:0]     cpu_req_be,
    output logic                        cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]       cpu_resp_rdata,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_WIDTH-1:0]       mem_req_addr,
    input  logic                        mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0]     mem_resp_rdata,
    output logic                        vc_probe_valid,
    output logic [VICTIM_TAG_WIDTH-1:0] vc_probe_tag,
    input  logic                        vc_probe_ready,
    input  logic                        vc_probe_hit,
    input  logic                        vc_probe_dirty,
    input  logic [LINE_BYTES*8-1:0]     vc_probe_line,
    output logic                        vc_evict_valid,
    output logic [VICTIM_TAG_WIDTH-1:0] vc_evict_tag,
    output logic [LINE_BYTES*8-1:0]     vc_evict_line,
    output logic                        vc_evict_dirty,
    input  logic                        vc_evict_ack,
    output logic [STAT_WIDTH-1:0]       stat_hits,
    output logic [STAT_WIDTH-1:0]       stat_misses,
    output logic [STAT_WIDTH-1:0]       stat_vc_hits
);
    localparam int LINE_BITS = LINE_BYTES * 8;
    localparam int BE_W      = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(LINE_BYTES);
    localparam int WB_W      = $clog2(BE_W);
    localparam int WORDS     = LINE_BITS / DATA_WIDTH;
    localparam int WSEL_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SETS      = CACHE_BYTES / (LINE_BYTES * WAYS);
    localparam int IDX_W     = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int TAG_W     = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0]      WAY_LAST = WAY_W'(WAYS - 1);
    localparam logic [WAY_W-1:0]      WAY_ONE  = WAY_W'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

    generate
        if (VICTIM_TAG_WIDTH != ADDR_WIDTH - OFF_W) begin : g_vtag_check
            $error("VICTIM_TAG_WIDTH must equal ADDR_WIDTH - log2(LINE_BYTES)");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_VC_PROBE, ST_EVICT,
        ST_MEM_REQ, ST_MEM_WAIT, ST_INSTALL, ST_RESPOND
    } state_t;

    state_t state_r, state_next_s;

    logic [LINE_BITS-1:0] data_r  [WAYS][SETS];
    logic [TAG_W-1:0]     tag_r   [WAYS][SETS];
    logic [WAYS-1:0]      valid_r [SETS];
    logic [WAYS-1:0]      dirty_r [SETS];
    logic [WAY_W-1:0]     rr_r    [SETS];

    logic                  req_rw_r;
    logic [ADDR_WIDTH-1:0] req_addr_r;
    logic [DATA_WIDTH-1:0] req_wdata_r;
    logic [BE_W-1:0]       req_be_r;
    logic [WAY_W-1:0]      victim_way_r;
    logic                  set_full_r, vc_hit_r, vc_dirty_r;
    logic [LINE_BITS-1:0]  fill_line_r;

    logic                        cpu_req_ready_r, cpu_resp_valid_r, mem_req_valid_r;
    logic                        vc_probe_valid_r, vc_evict_valid_r, vc_evict_dirty_r;
    logic [DATA_WIDTH-1:0]       cpu_resp_rdata_r;
    logic [VICTIM_TAG_WIDTH-1:0] vc_evict_tag_r;
    logic [LINE_BITS-1:0]        vc_evict_line_r;
    logic [STAT_WIDTH-1:0]       stat_hits_r, stat_misses_r, stat_vc_hits_r;

    logic [IDX_W-1:0]     idx_s;
    logic [TAG_W-1:0]     tag_s;
    logic [WSEL_W-1:0]    wsel_s;
    logic [BE_W-1:0]      eff_be_s;
    logic                 accept_s, hit_s, set_full_s;
    logic [WAY_W-1:0]     hit_way_s, victim_way_s;
    logic [LINE_BITS-1:0] hit_merge_s, install_line_s;

    // Overlay the enabled bytes of wdata onto the selected word of a line.
    function automatic logic [LINE_BITS-1:0] merge_word(input logic [LINE_BITS-1:0]  line,
                                                        input logic [WSEL_W-1:0]     sel,
                                                        input logic [DATA_WIDTH-1:0] wdata,
                                                        input logic [BE_W-1:0]       be);
        logic [LINE_BITS-1:0] res;
        res = line;
        for (int b = 0; b < BE_W; b++) begin
            res[int'(sel)*DATA_WIDTH + b*8 +: 8] = be[b] ? wdata[b*8 +: 8]
                                                         : line[int'(sel)*DATA_WIDTH + b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] get_word(input logic [LINE_BITS-1:0] line,
                                                       input logic [WSEL_W-1:0]    sel);
        return line[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    assign accept_s = cpu_req_valid && (state_r == ST_IDLE);
    assign idx_s    = req_addr_r[OFF_W +: IDX_W];
    assign tag_s    = req_addr_r[ADDR_WIDTH-1 -: TAG_W];
    assign wsel_s   = req_addr_r[WB_W +: WSEL_W];
    // Reads reuse the merge path with all byte enables cleared.
    assign eff_be_s       = req_rw_r ? req_be_r : {BE_W{1'b0}};
    assign hit_merge_s    = merge_word(data_r[hit_way_s][idx_s], wsel_s, req_wdata_r, eff_be_s);
    assign install_line_s = merge_word(fill_line_r, wsel_s, req_wdata_r, eff_be_s);

    // Tag compare across ways plus victim choice (lowest invalid way, else RR pointer).
    always_comb begin
        hit_s        = 1'b0;
        hit_way_s    = {WAY_W{1'b0}};
        set_full_s   = 1'b1;
        victim_way_s = rr_r[idx_s];
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s    = (valid_r[idx_s][w] && (tag_r[w][idx_s] == tag_s)) ? WAY_W'(w) : hit_way_s;
            hit_s        = hit_s | (valid_r[idx_s][w] && (tag_r[w][idx_s] == tag_s));
            victim_way_s = valid_r[idx_s][w] ? victim_way_s : WAY_W'(w);
            set_full_s   = set_full_s & valid_r[idx_s][w];
        end
    end

    // Next-state logic of the miss-handling FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:     state_next_s = accept_s ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP:   state_next_s = hit_s ? ST_RESPOND : ST_VC_PROBE;
            ST_VC_PROBE: begin
                if (vc_probe_ready) begin
                    state_next_s = set_full_r ? ST_EVICT : (vc_probe_hit ? ST_INSTALL : ST_MEM_REQ);
                end else begin
                    state_next_s = ST_VC_PROBE;
                end
            end
            ST_EVICT: begin
                if (vc_evict_ack) begin
                    state_next_s = vc_hit_r ? ST_INSTALL : ST_MEM_REQ;
                end else begin
                    state_next_s = ST_EVICT;
                end
            end
            ST_MEM_REQ:  state_next_s = mem_req_ready ? ST_MEM_WAIT : ST_MEM_REQ;
            ST_MEM_WAIT: state_next_s = mem_resp_valid ? ST_INSTALL : ST_MEM_WAIT;
            ST_INSTALL:  state_next_s = ST_RESPOND;
            ST_RESPOND:  state_next_s = ST_IDLE;
            default:     state_next_s = ST_IDLE;
        endcase
    end

    // State, latched request, line metadata and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            req_rw_r         <= 1'b0;
            req_addr_r       <= {ADDR_WIDTH{1'b0}};
            req_wdata_r      <= {DATA_WIDTH{1'b0}};
            req_be_r         <= {BE_W{1'b0}};
            victim_way_r     <= {WAY_W{1'b0}};
            set_full_r       <= 1'b0;
            vc_hit_r         <= 1'b0;
            vc_dirty_r       <= 1'b0;
            fill_line_r      <= {LINE_BITS{1'b0}};
            cpu_req_ready_r  <= 1'b1;
            cpu_resp_valid_r <= 1'b0;
            cpu_resp_rdata_r <= {DATA_WIDTH{1'b0}};
            mem_req_valid_r  <= 1'b0;
            vc_probe_valid_r <= 1'b0;
            vc_evict_valid_r <= 1'b0;
            vc_evict_tag_r   <= {VICTIM_TAG_WIDTH{1'b0}};
            vc_evict_line_r  <= {LINE_BITS{1'b0}};
            vc_evict_dirty_r <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= {WAYS{1'b0}};
                dirty_r[s] <= {WAYS{1'b0}};
                rr_r[s]    <= {WAY_W{1'b0}};
            end
        end else begin
            state_r          <= state_next_s;
            cpu_req_ready_r  <= (state_next_s == ST_IDLE);
            cpu_resp_valid_r <= (state_next_s == ST_RESPOND);
            vc_probe_valid_r <= (state_next_s == ST_VC_PROBE);
            vc_evict_valid_r <= (state_next_s == ST_EVICT);
            mem_req_valid_r  <= (state_next_s == ST_MEM_REQ);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        req_rw_r    <= cpu_req_rw;
                        req_addr_r  <= cpu_req_addr;
                        req_wdata_r <= cpu_req_wdata;
                        req_be_r    <= cpu_req_be;
                    end
                end
                ST_LOOKUP: begin
                    victim_way_r <= victim_way_s;
                    set_full_r   <= set_full_s;
                    if (hit_s) begin
                        cpu_resp_rdata_r <= get_word(hit_merge_s, wsel_s);
                        if (req_rw_r) begin
                            dirty_r[idx_s][hit_way_s] <= 1'b1;
                        end
                    end
                end
                ST_VC_PROBE: begin
                    if (vc_probe_ready) begin
                        vc_hit_r   <= vc_probe_hit;
                        vc_dirty_r <= vc_probe_dirty;
                        if (vc_probe_hit) begin
                            fill_line_r <= vc_probe_line;
                        end
                        // Capture the victim now so the evict payload is stable while valid.
                        if (set_full_r) begin
                            vc_evict_tag_r   <= {tag_r[victim_way_r][idx_s], idx_s};
                            vc_evict_line_r  <= data_r[victim_way_r][idx_s];
                            vc_evict_dirty_r <= dirty_r[idx_s][victim_way_r];
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        fill_line_r <= mem_resp_rdata;
                    end
                end
                ST_INSTALL: begin
                    valid_r[idx_s][victim_way_r] <= 1'b1;
                    dirty_r[idx_s][victim_way_r] <= req_rw_r | (vc_hit_r & vc_dirty_r);
                    cpu_resp_rdata_r             <= get_word(install_line_s, wsel_s);
                    if (set_full_r) begin
                        rr_r[idx_s] <= (rr_r[idx_s] == WAY_LAST) ? {WAY_W{1'b0}} : rr_r[idx_s] + WAY_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line data and tags; valid_r gates every use, so these need no reset.
    always_ff @(posedge clk) begin
        if ((state_r == ST_LOOKUP) && hit_s && req_rw_r) begin
            data_r[hit_way_s][idx_s] <= hit_merge_s;
        end else if (state_r == ST_INSTALL) begin
            data_r[victim_way_r][idx_s] <= install_line_s;
            tag_r[victim_way_r][idx_s]  <= tag_s;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits_r    <= {STAT_WIDTH{1'b0}};
            stat_misses_r  <= {STAT_WIDTH{1'b0}};
            stat_vc_hits_r <= {STAT_WIDTH{1'b0}};
        end else begin
            if ((state_r == ST_LOOKUP) && hit_s && (stat_hits_r != STAT_MAX)) begin
                stat_hits_r <= stat_hits_r + STAT_ONE;
            end
            if ((state_r == ST_LOOKUP) && !hit_s && (stat_misses_r != STAT_MAX)) begin
                stat_misses_r <= stat_misses_r + STAT_ONE;
            end
            if ((state_r == ST_VC_PROBE) && vc_probe_ready && vc_probe_hit && (stat_vc_hits_r != STAT_MAX)) begin
                stat_vc_hits_r <= stat_vc_hits_r + STAT_ONE;
            end
        end
    end

    assign cpu_req_ready  = cpu_req_ready_r;
    assign cpu_resp_valid = cpu_resp_valid_r;
    assign cpu_resp_rdata = cpu_resp_rdata_r;
    assign mem_req_valid  = mem_req_valid_r;
    assign mem_req_addr   = {req_addr_r[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign vc_probe_valid = vc_probe_valid_r;
    assign vc_probe_tag   = req_addr_r[ADDR_WIDTH-1:OFF_W];
    assign vc_evict_valid = vc_evict_valid_r;
    assign vc_evict_tag   = vc_evict_tag_r;
    assign vc_evict_line  = vc_evict_line_r;
    assign vc_evict_dirty = vc_evict_dirty_r;
    assign stat_hits      = stat_hits_r;
    assign stat_misses    = stat_misses_r;
    assign stat_vc_hits   = stat_vc_hits_r;

endmodule

// File: tb/tb_l1_cache_sa_vc.sv
// Directed testbench for l1_cache_sa_vc (default parameters: 2 ways, 16 sets,
// 16-byte lines). Memory and victim cache are modelled by the transaction task,
// which answers every handshake immediately and records what it saw.
module tb_l1_cache_sa_vc;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_rw = 1'b0;
    logic [31:0]  cpu_req_addr = 32'h0, cpu_req_wdata = 32'h0;
    logic [3:0]   cpu_req_be = 4'h0;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_rdata;
    logic         mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_rdata = 128'h0;
    logic         vc_probe_valid, vc_probe_ready = 1'b0, vc_probe_hit = 1'b0, vc_probe_dirty = 1'b0;
    logic [27:0]  vc_probe_tag;
    logic [127:0] vc_probe_line = 128'h0;
    logic         vc_evict_valid, vc_evict_dirty, vc_evict_ack = 1'b0;
    logic [27:0]  vc_evict_tag;
    logic [127:0] vc_evict_line;
    logic [31:0]  stat_hits, stat_misses, stat_vc_hits;

    l1_cache_sa_vc dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_rw(cpu_req_rw),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .vc_probe_valid(vc_probe_valid), .vc_probe_tag(vc_probe_tag), .vc_probe_ready(vc_probe_ready),
        .vc_probe_hit(vc_probe_hit), .vc_probe_dirty(vc_probe_dirty), .vc_probe_line(vc_probe_line),
        .vc_evict_valid(vc_evict_valid), .vc_evict_tag(vc_evict_tag), .vc_evict_line(vc_evict_line),
        .vc_evict_dirty(vc_evict_dirty), .vc_evict_ack(vc_evict_ack),
        .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_vc_hits(stat_vc_hits)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] LINE_A  = {32'h55667788, 32'h99AABBCC, 32'h11223344, 32'hDEADBEEF};
    localparam logic [127:0] LINE_AM = {32'h55667788, 32'h99AABBCC, 32'h112233AA, 32'hDEADBEEF};
    localparam logic [127:0] LINE_B  = {32'h0B0B0B03, 32'h0B0B0B02, 32'h0B0B0B01, 32'hB0B0B0B0};
    localparam logic [127:0] LINE_C  = {32'h0C0C0C03, 32'h0C0C0C02, 32'h0C0C0C01, 32'hC0C0C0C0};
    localparam logic [127:0] LINE_D  = {32'h0D0D0D03, 32'h0D0D0D02, 32'h0D0D0D01, 32'hD00DD00D};

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Responder configuration and observations of the last transaction.
    logic         vc_hit_cfg = 1'b0, vc_dirty_cfg = 1'b0;
    logic [127:0] vc_line_cfg = 128'h0, mem_line_cfg = 128'h0;
    logic         obs_got;
    int           obs_lat, obs_probe_cnt, obs_probe_cyc, obs_evict_cnt, obs_evict_cyc, obs_mem_cnt;
    logic [31:0]  obs_rdata, obs_mem_addr;
    logic [27:0]  obs_probe_tag, obs_evict_tag;
    logic         obs_evict_dirty;
    logic [127:0] obs_evict_line;

    task automatic clear_inputs;
        cpu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        vc_probe_ready = 1'b0; vc_probe_hit = 1'b0; vc_probe_dirty = 1'b0; vc_evict_ack = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One CPU transaction; memory and VC answer every handshake at once.
    task automatic xact(input logic rw, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        int   cyc;
        logic mem_pend;
        obs_got = 1'b0; obs_lat = -1; obs_rdata = 32'h0;
        obs_probe_cnt = 0; obs_probe_cyc = -1; obs_probe_tag = 28'h0;
        obs_evict_cnt = 0; obs_evict_cyc = -1; obs_evict_tag = 28'h0; obs_evict_dirty = 1'b0; obs_evict_line = 128'h0;
        obs_mem_cnt = 0; obs_mem_addr = 32'h0;
        mem_pend = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!cpu_req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_wdata = wdata; cpu_req_be = be;
        @(negedge clk);
        // Scramble the request inputs: the DUT must have latched them.
        cpu_req_valid = 1'b0; cpu_req_rw = ~rw; cpu_req_addr = 32'hFFFF_FFF0;
        cpu_req_wdata = 32'hFFFF_FFFF; cpu_req_be = 4'hF;
        cyc = 1;
        while (!obs_got && cyc < 60) begin
            if (cpu_resp_valid) begin
                obs_got = 1'b1; obs_lat = cyc; obs_rdata = cpu_resp_rdata;
            end
            vc_probe_ready = 1'b0; vc_evict_ack = 1'b0; mem_req_ready = 1'b0;
            mem_resp_valid = mem_pend; mem_resp_rdata = mem_line_cfg; mem_pend = 1'b0;
            if (vc_probe_valid) begin
                vc_probe_ready = 1'b1; vc_probe_hit = vc_hit_cfg; vc_probe_dirty = vc_dirty_cfg;
                vc_probe_line = vc_line_cfg;
                obs_probe_cnt++; obs_probe_cyc = cyc; obs_probe_tag = vc_probe_tag;
            end
            if (vc_evict_valid) begin
                vc_evict_ack = 1'b1;
                obs_evict_cnt++; obs_evict_cyc = cyc; obs_evict_tag = vc_evict_tag;
                obs_evict_dirty = vc_evict_dirty; obs_evict_line = vc_evict_line;
            end
            if (mem_req_valid) begin
                mem_req_ready = 1'b1; mem_pend = 1'b1;
                obs_mem_cnt++; obs_mem_addr = mem_req_addr;
            end
            @(negedge clk);
            cyc++;
        end
        clear_inputs();
    endtask

    task automatic test_reset;
        do_reset();
        chk_cnt++; if (cpu_req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cpu_req_ready); else pass_cnt++;
        chk_cnt++; if ({cpu_resp_valid, mem_req_valid, vc_probe_valid, vc_evict_valid, vc_evict_dirty} !== 5'b0)
            $display("FAIL reset_valids got %b exp 00000", {cpu_resp_valid, mem_req_valid, vc_probe_valid, vc_evict_valid, vc_evict_dirty});
        else pass_cnt++;
        chk_cnt++; if ({stat_hits, stat_misses, stat_vc_hits} !== 96'h0)
            $display("FAIL reset_stats got %h/%h/%h exp 0", stat_hits, stat_misses, stat_vc_hits); else pass_cnt++;
        chk_cnt++; if ({mem_req_addr, vc_probe_tag, vc_evict_tag, cpu_resp_rdata} !== 120'h0)
            $display("FAIL reset_payload got %h %h %h %h exp 0", mem_req_addr, vc_probe_tag, vc_evict_tag, cpu_resp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_cold_read;
        vc_hit_cfg = 1'b0; mem_line_cfg = LINE_A;
        xact(1'b0, 32'h100, 32'h0, 4'h0);
        chk_cnt++; if (obs_got !== 1'b1) $display("FAIL cold_resp got %b exp 1", obs_got); else pass_cnt++;
        chk_cnt++; if (obs_rdata !== 32'hDEADBEEF) $display("FAIL cold_rdata got %h exp deadbeef", obs_rdata); else pass_cnt++;
        chk_cnt++; if (obs_probe_tag !== 28'h0000010) $display("FAIL cold_probe_tag got %h exp 0000010", obs_probe_tag); else pass_cnt++;
        chk_cnt++; if (obs_evict_cnt !== 0) $display("FAIL cold_no_evict got %0d exp 0", obs_evict_cnt); else pass_cnt++;
        chk_cnt++; if (obs_mem_cnt !== 1 || obs_mem_addr !== 32'h100)
            $display("FAIL cold_mem got cnt %0d addr %h exp 1 00000100", obs_mem_cnt, obs_mem_addr); else pass_cnt++;
        chk_cnt++; if (stat_misses !== 32'd1 || stat_hits !== 32'd0)
            $display("FAIL cold_stats got miss %0d hit %0d exp 1 0", stat_misses, stat_hits); else pass_cnt++;
    endtask

    task automatic test_read_hit;
        xact(1'b0, 32'h100, 32'h0, 4'h0);
        chk_cnt++; if (obs_lat !== 2) $display("FAIL hit_latency got %0d exp 2", obs_lat); else pass_cnt++;
        chk_cnt++; if (obs_rdata !== 32'hDEADBEEF) $display("FAIL hit_rdata got %h exp deadbeef", obs_rdata); else pass_cnt++;
        chk_cnt++; if (obs_probe_cnt + obs_mem_cnt + obs_evict_cnt !== 0)
            $display("FAIL hit_no_traffic got %0d exp 0", obs_probe_cnt + obs_mem_cnt + obs_evict_cnt); else pass_cnt++;
        chk_cnt++; if (stat_hits !== 32'd1) $display("FAIL hit_stat got %0d exp 1", stat_hits); else pass_cnt++;
    endtask

    task automatic test_write_merge;
        xact(1'b1, 32'h104, 32'h000000AA, 4'b0001);
        chk_cnt++; if (obs_lat !== 2 || obs_rdata !== 32'h112233AA)
            $display("FAIL wr_hit got lat %0d data %h exp 2 112233aa", obs_lat, obs_rdata); else pass_cnt++;
        xact(1'b0, 32'h104, 32'h0, 4'h0);
        chk_cnt++; if (obs_rdata !== 32'h112233AA) $display("FAIL wr_readback got %h exp 112233aa", obs_rdata); else pass_cnt++;
        chk_cnt++; if (stat_hits !== 32'd3) $display("FAIL wr_stat_hits got %0d exp 3", stat_hits); else pass_cnt++;
    endtask

    // Way0 holds the dirty 0x100 line; fill way1, then displace way0.
    task automatic test_dirty_evict;
        mem_line_cfg = LINE_B;
        xact(1'b0, 32'h000, 32'h0, 4'h0);
        chk_cnt++; if (obs_rdata !== 32'hB0B0B0B0 || obs_evict_cnt !== 0)
            $display("FAIL de_fill got %h evicts %0d exp b0b0b0b0 0", obs_rdata, obs_evict_cnt); else pass_cnt++;
        mem_line_cfg = LINE_C;
        xact(1'b0, 32'h200, 32'h0, 4'h0);
        chk_cnt++; if (obs_evict_cnt !== 1 || obs_evict_tag !== 28'h0000010 || obs_evict_dirty !== 1'b1)
            $display("FAIL de_evict got cnt %0d tag %h dirty %b exp 1 0000010 1", obs_evict_cnt, obs_evict_tag, obs_evict_dirty);
        else pass_cnt++;
        chk_cnt++; if (obs_evict_line !== LINE_AM) $display("FAIL de_evict_line got %h exp %h", obs_evict_line, LINE_AM); else pass_cnt++;
        chk_cnt++; if (obs_probe_cyc < 0 || obs_evict_cyc <= obs_probe_cyc)
            $display("FAIL de_order got probe %0d evict %0d exp probe first", obs_probe_cyc, obs_evict_cyc); else pass_cnt++;
        chk_cnt++; if (obs_rdata !== 32'hC0C0C0C0 || obs_mem_addr !== 32'h200)
            $display("FAIL de_rdata got %h addr %h exp c0c0c0c0 00000200", obs_rdata, obs_mem_addr); else pass_cnt++;
        chk_cnt++; if (stat_misses !== 32'd3 || stat_hits !== 32'd3)
            $display("FAIL de_stats got miss %0d hit %0d exp 3 3", stat_misses, stat_hits); else pass_cnt++;
    endtask

    task automatic test_rr_evict;
        do_reset();
        mem_line_cfg = LINE_B; xact(1'b0, 32'h000, 32'h0, 4'h0);
        mem_line_cfg = LINE_A; xact(1'b0, 32'h100, 32'h0, 4'h0);
        chk_cnt++; if (obs_evict_cnt !== 0 || obs_rdata !== 32'hDEADBEEF)
            $display("FAIL rr_fill got evicts %0d data %h exp 0 deadbeef", obs_evict_cnt, obs_rdata); else pass_cnt++;
        xact(1'b1, 32'h104, 32'h000000AA, 4'b0001);
        mem_line_cfg = LINE_C; xact(1'b0, 32'h200, 32'h0, 4'h0);
        chk_cnt++; if (obs_evict_cnt !== 1 || obs_evict_tag !== 28'h0000000 || obs_evict_dirty !== 1'b0)
            $display("FAIL rr_evict got cnt %0d tag %h dirty %b exp 1 0000000 0", obs_evict_cnt, obs_evict_tag, obs_evict_dirty);
        else pass_cnt++;
        chk_cnt++; if (obs_evict_line !== LINE_B) $display("FAIL rr_evict_line got %h exp %h", obs_evict_line, LINE_B); else pass_cnt++;
        chk_cnt++; if (obs_probe_tag !== 28'h0000020) $display("FAIL rr_probe_tag got %h exp 0000020", obs_probe_tag); else pass_cnt++;
    endtask

    // RR pointer is now 1, so the dirty 0x100 line in way1 is the victim.
    task automatic test_vc_hit;
        vc_hit_cfg = 1'b1; vc_dirty_cfg = 1'b1; vc_line_cfg = LINE_D; mem_line_cfg = LINE_C;
        xact(1'b0, 32'h000, 32'h0, 4'h0);
        vc_hit_cfg = 1'b0; vc_dirty_cfg = 1'b0;
        chk_cnt++; if (obs_mem_cnt !== 0) $display("FAIL vc_no_mem got %0d exp 0", obs_mem_cnt); else pass_cnt++;
        chk_cnt++; if (obs_evict_tag !== 28'h0000010 || obs_evict_dirty !== 1'b1 || obs_evict_line !== LINE_AM)
            $display("FAIL vc_evict got tag %h dirty %b line %h", obs_evict_tag, obs_evict_dirty, obs_evict_line); else pass_cnt++;
        chk_cnt++; if (obs_probe_cyc < 0 || obs_evict_cyc <= obs_probe_cyc)
            $display("FAIL vc_order got probe %0d evict %0d exp probe first", obs_probe_cyc, obs_evict_cyc); else pass_cnt++;
        chk_cnt++; if (obs_rdata !== 32'hD00DD00D) $display("FAIL vc_rdata got %h exp d00dd00d", obs_rdata); else pass_cnt++;
        chk_cnt++; if (stat_vc_hits !== 32'd1) $display("FAIL vc_stat got %0d exp 1", stat_vc_hits); else pass_cnt++;
        // Pointer wrapped to 0: 0x300 displaces clean 0x200, then 0x400 displaces the VC-installed dirty 0x000.
        xact(1'b0, 32'h300, 32'h0, 4'h0);
        chk_cnt++; if (obs_evict_tag !== 28'h0000020 || obs_evict_dirty !== 1'b0)
            $display("FAIL vc_wrap_evict got tag %h dirty %b exp 0000020 0", obs_evict_tag, obs_evict_dirty); else pass_cnt++;
        xact(1'b0, 32'h400, 32'h0, 4'h0);
        chk_cnt++; if (obs_evict_tag !== 28'h0000000 || obs_evict_dirty !== 1'b1 || obs_evict_line !== LINE_D)
            $display("FAIL vc_installed_dirty got tag %h dirty %b line %h", obs_evict_tag, obs_evict_dirty, obs_evict_line);
        else pass_cnt++;
        chk_cnt++; if (stat_misses !== 32'd6 || stat_hits !== 32'd1 || stat_vc_hits !== 32'd1)
            $display("FAIL vc_stats got %0d/%0d/%0d exp 6/1/1", stat_misses, stat_hits, stat_vc_hits); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int   cyc;
        logic in_wait, mem_acc;
        in_wait = 1'b0; mem_acc = 1'b0;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h500; cpu_req_be = 4'h0;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cyc = 1;
        while (!in_wait && cyc < 40) begin
            vc_probe_ready = 1'b0; vc_evict_ack = 1'b0; mem_req_ready = 1'b0; vc_probe_hit = 1'b0;
            if (mem_acc) begin
                in_wait = 1'b1;
            end else begin
                if (vc_probe_valid) vc_probe_ready = 1'b1;
                if (vc_evict_valid) vc_evict_ack = 1'b1;
                if (mem_req_valid) begin
                    mem_req_ready = 1'b1; mem_acc = 1'b1;
                end
            end
            if (!in_wait) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk_cnt++; if (in_wait !== 1'b1) $display("FAIL mid_reached_wait got %b exp 1", in_wait); else pass_cnt++;
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk_cnt++; if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
            $display("FAIL mid_rst_ctrl got rdy %b resp %b mreq %b exp 1 0 0", cpu_req_ready, cpu_resp_valid, mem_req_valid);
        else pass_cnt++;
        chk_cnt++; if (mem_req_addr !== 32'h0 || stat_misses !== 32'd0 || vc_evict_tag !== 28'h0)
            $display("FAIL mid_rst_data got addr %h miss %0d etag %h exp 0", mem_req_addr, stat_misses, vc_evict_tag);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        // Stray responses in IDLE must be ignored.
        mem_resp_valid = 1'b1; mem_resp_rdata = LINE_C; vc_probe_ready = 1'b1; vc_evict_ack = 1'b1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        chk_cnt++; if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0)
            $display("FAIL mid_stray got rdy %b resp %b exp 1 0", cpu_req_ready, cpu_resp_valid); else pass_cnt++;
        mem_line_cfg = LINE_A;
        xact(1'b0, 32'h100, 32'h0, 4'h0);
        chk_cnt++; if (obs_mem_cnt !== 1 || obs_rdata !== 32'hDEADBEEF)
            $display("FAIL mid_reread got mem %0d data %h exp 1 deadbeef", obs_mem_cnt, obs_rdata); else pass_cnt++;
        chk_cnt++; if (stat_misses !== 32'd1 || stat_hits !== 32'd0)
            $display("FAIL mid_stats got miss %0d hit %0d exp 1 0", stat_misses, stat_hits); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_merge();
        test_dirty_evict();
        test_rr_evict();
        test_vc_hit();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
